// File: rtl/mmio_io_bridge_pkg.sv
// Shared types, register map and lane helpers for the MMIO/RAM bridge.
// The lane helpers are also meant for the fetch byte-select path.
package mmio_io_bridge_pkg;

    // Access size carried on the bmd bus
    typedef enum logic [1:0] {
        BMD_BYTE = 2'd0,
        BMD_HALF = 2'd1,
        BMD_WORD = 2'd2,
        BMD_QUAD = 2'd3
    } bmd_t;

    // MMIO register index (word offset from IO_BASE)
    localparam logic [1:0] MMIO_OUT    = 2'd0;
    localparam logic [1:0] MMIO_IN     = 2'd1;
    localparam logic [1:0] MMIO_STATUS = 2'd2;

    // STATUS register layout
    localparam int STATUS_OUT_FULL_BIT  = 0;
    localparam int STATUS_IN_EMPTY_BIT  = 1;
    localparam int STATUS_OUT_COUNT_LSB = 8;
    localparam int STATUS_IN_COUNT_LSB  = 16;

    // One stage of the load-return delay line
    typedef struct packed {
        logic        valid;
        logic        is_io;
        logic [2:0]  offset;
        bmd_t        bmd;
        logic [63:0] io_rdata;
    } ld_stage_t;

    // Number of bytes touched by an access size
    function automatic logic [3:0] bmd_bytes(input bmd_t b);
        case (b)
            BMD_BYTE: return 4'd1;
            BMD_HALF: return 4'd2;
            BMD_WORD: return 4'd4;
            BMD_QUAD: return 4'd8;
            default:  return 4'd1;
        endcase
    endfunction

    // Force the byte offset to the natural alignment of the access size
    function automatic logic [2:0] align_offset(input logic [2:0] off, input bmd_t b);
        case (b)
            BMD_BYTE: return off;
            BMD_HALF: return {off[2:1], 1'b0};
            BMD_WORD: return {off[2], 2'b00};
            BMD_QUAD: return 3'b000;
            default:  return off;
        endcase
    endfunction

    // Lanes are big-endian: byte offset k sits at [63-8k -: 8], so an
    // n-byte access at offset k is the right-justified value shifted
    // left by (8-k-n) bytes. Offset must already be aligned.
    function automatic logic [2:0] lane_shift(input logic [2:0] off, input bmd_t b);
        logic [3:0] s;
        s = 4'd8 - {1'b0, off} - bmd_bytes(b);
        return s[2:0];
    endfunction

    // Right-justified data mask for an access size
    function automatic logic [63:0] size_mask(input bmd_t b);
        case (b)
            BMD_BYTE: return 64'h0000_0000_0000_00FF;
            BMD_HALF: return 64'h0000_0000_0000_FFFF;
            BMD_WORD: return 64'h0000_0000_FFFF_FFFF;
            BMD_QUAD: return 64'hFFFF_FFFF_FFFF_FFFF;
            default:  return 64'h0000_0000_0000_00FF;
        endcase
    endfunction

    // Byte-enable pattern for a store
    function automatic logic [7:0] lane_we(input logic [2:0] off, input bmd_t b);
        logic [7:0] m;
        case (b)
            BMD_BYTE: m = 8'h01;
            BMD_HALF: m = 8'h03;
            BMD_WORD: m = 8'h0F;
            BMD_QUAD: m = 8'hFF;
            default:  m = 8'h01;
        endcase
        return m << lane_shift(off, b);
    endfunction

    // Place right-justified store data onto its RAM lanes
    function automatic logic [63:0] lane_insert(input logic [63:0] d, input logic [2:0] off,
                                                input bmd_t b);
        return (d & size_mask(b)) << {lane_shift(off, b), 3'b000};
    endfunction

    // Pull an access out of a RAM word, zero-extended
    function automatic logic [63:0] lane_extract(input logic [63:0] w, input logic [2:0] off,
                                                 input bmd_t b);
        return (w >> {lane_shift(off, b), 3'b000}) & size_mask(b);
    endfunction

    // Clamp a FIFO occupancy to the 8-bit STATUS field
    function automatic logic [7:0] sat_count8(input logic [31:0] count);
        if (count > 32'd255) begin
            return 8'hFF;
        end else begin
            return count[7:0];
        end
    endfunction

endpackage

// File: rtl/mmio_io_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count. Full is taken from the
// registered count, so a pop in the same cycle never admits a push.
module sync_fifo
    import mmio_io_bridge_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_io_bridge.sv
// Virtual-to-physical bridge: routes core loads/stores to 64-bit RAM or to
// a small MMIO window with buffered OUT/IN byte channels and a STATUS word.
module mmio_io_bridge
    import mmio_io_bridge_pkg::*;
#(
    parameter int          LOAD_LATENCY = 1,
    parameter logic [31:0] IO_BASE      = 32'hfffff000,
    parameter int          OUT_DEPTH    = 16,
    parameter int          IN_DEPTH     = 16,
    parameter int          OUT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             virt_we,
    input  logic             virt_req,
    input  logic [31:0]      virt_mem_addr,
    input  logic [1:0]       virt_mem_bmd,
    input  logic [63:0]      virt_st_data,
    output logic [63:0]      virt_ld_data,
    output logic [28:0]      phys_mem_addr,
    output logic [7:0]       phys_we,
    output logic [63:0]      phys_st_data,
    input  logic [63:0]      phys_ld_data,
    output logic [OUT_W-1:0] out_data,
    output logic             out_req,
    input  logic             out_busy,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             io_stall
);

    localparam int          OCW     = $clog2(OUT_DEPTH) + 1;
    localparam int          ICW     = $clog2(IN_DEPTH) + 1;
    localparam logic [28:0] IO_WORD = IO_BASE[31:3];

    bmd_t             bmd_s;
    logic [2:0]       offset_s;
    logic [28:0]      io_delta_s;
    logic             is_io_s;
    logic [1:0]       reg_sel_s;
    logic             out_push_s;
    logic             out_pop_s;
    logic             out_full_s;
    logic             out_empty_s;
    logic [OCW-1:0]   out_count_s;
    logic             in_push_s;
    logic             in_pop_s;
    logic             in_full_s;
    logic             in_empty_s;
    logic [ICW-1:0]   in_count_s;
    logic [7:0]       in_head_s;
    logic [63:0]      status_s;
    logic [63:0]      io_rdata_s;
    ld_stage_t        ld_new_s;
    ld_stage_t        ld_last_s;
    ld_stage_t        pipe_r [LOAD_LATENCY];
    logic [63:0]      ld_final_s;
    logic [63:0]      ld_hold_r;

    assign bmd_s         = bmd_t'(virt_mem_bmd);
    assign offset_s      = align_offset(virt_mem_addr[2:0], bmd_s);
    assign io_delta_s    = virt_mem_addr[31:3] - IO_WORD;
    assign is_io_s       = virt_req & (io_delta_s < 29'd3);
    assign reg_sel_s     = io_delta_s[1:0];
    assign phys_mem_addr = virt_mem_addr[31:3];
    assign phys_st_data  = lane_insert(virt_st_data, offset_s, bmd_s);

    // RAM byte enables: only for non-MMIO stores, and never while in reset
    always_comb begin
        phys_we = 8'h00;
        if (rstn && virt_req && virt_we && !is_io_s) begin
            phys_we = lane_we(offset_s, bmd_s);
        end else begin
            phys_we = 8'h00;
        end
    end

    // MMIO channel handshakes and the store back-pressure
    always_comb begin
        io_stall   = 1'b0;
        out_push_s = 1'b0;
        in_pop_s   = 1'b0;
        if (is_io_s && virt_we && (reg_sel_s == MMIO_OUT)) begin
            io_stall   = out_full_s;
            out_push_s = ~out_full_s;
        end else if (is_io_s && !virt_we && (reg_sel_s == MMIO_IN)) begin
            in_pop_s   = ~in_empty_s;
        end else begin
            io_stall   = 1'b0;
            out_push_s = 1'b0;
            in_pop_s   = 1'b0;
        end
    end

    assign out_req   = ~out_empty_s;
    assign out_pop_s = ~out_empty_s & ~out_busy;
    assign in_ready  = ~in_full_s;
    assign in_push_s = in_valid & ~in_full_s;

    sync_fifo #(
        .W     (OUT_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (out_push_s),
        .wdata (virt_st_data[OUT_W-1:0]),
        .pop   (out_pop_s),
        .rdata (out_data),
        .full  (out_full_s),
        .empty (out_empty_s),
        .count (out_count_s)
    );

    sync_fifo #(
        .W     (8),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_push_s),
        .wdata (in_data),
        .pop   (in_pop_s),
        .rdata (in_head_s),
        .full  (in_full_s),
        .empty (in_empty_s),
        .count (in_count_s)
    );

    // STATUS word assembled from live FIFO state
    always_comb begin
        status_s = 64'd0;
        status_s[STATUS_OUT_FULL_BIT]                = out_full_s;
        status_s[STATUS_IN_EMPTY_BIT]                = in_empty_s;
        status_s[STATUS_OUT_COUNT_LSB +: 8]          = sat_count8(32'(out_count_s));
        status_s[STATUS_IN_COUNT_LSB +: 8]           = sat_count8(32'(in_count_s));
    end

    // MMIO read data, captured in the request cycle (OUT reads as zero)
    always_comb begin
        io_rdata_s = 64'd0;
        if (is_io_s) begin
            case (reg_sel_s)
                MMIO_IN:     io_rdata_s = in_empty_s ? 64'd0 : {56'd0, in_head_s};
                MMIO_STATUS: io_rdata_s = status_s;
                default:     io_rdata_s = 64'd0;
            endcase
        end else begin
            io_rdata_s = 64'd0;
        end
    end

    // New delay-line entry describing this cycle's load
    always_comb begin
        ld_new_s          = '0;
        ld_new_s.valid    = virt_req & ~virt_we;
        ld_new_s.is_io    = is_io_s;
        ld_new_s.offset   = offset_s;
        ld_new_s.bmd      = bmd_s;
        ld_new_s.io_rdata = io_rdata_s;
    end

    // Delay line aligning load bookkeeping with the RAM read latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LOAD_LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= ld_new_s;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign ld_last_s = pipe_r[LOAD_LATENCY-1];

    // Final-stage load value: MMIO data or the lane extracted from RAM
    always_comb begin
        ld_final_s = 64'd0;
        if (ld_last_s.is_io) begin
            ld_final_s = ld_last_s.io_rdata;
        end else begin
            ld_final_s = lane_extract(phys_ld_data, ld_last_s.offset, ld_last_s.bmd);
        end
    end

    // Remember the last returned load so idle cycles keep it stable
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ld_hold_r <= 64'd0;
        end else if (ld_last_s.valid) begin
            ld_hold_r <= ld_final_s;
        end else begin
            ld_hold_r <= ld_hold_r;
        end
    end

    // Load result: live on the return cycle, held otherwise
    always_comb begin
        virt_ld_data = 64'd0;
        if (ld_last_s.valid) begin
            virt_ld_data = ld_final_s;
        end else begin
            virt_ld_data = ld_hold_r;
        end
    end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Self-checking bench for mmio_io_bridge: RAM lane mapping, OUT FIFO with
// back-pressure, IN FIFO reads, STATUS and mid-transfer reset.
module tb_mmio_io_bridge;

    localparam int          LAT    = 1;
    localparam logic [31:0] IO_OUT = 32'hfffff000;
    localparam logic [31:0] IO_IN  = 32'hfffff008;
    localparam logic [31:0] IO_ST  = 32'hfffff010;
    localparam logic [63:0] RAMW   = 64'h0011223344556677;

    logic        clk = 1'b0;
    logic        rstn;
    logic        virt_we, virt_req;
    logic [31:0] virt_mem_addr;
    logic [1:0]  virt_mem_bmd;
    logic [63:0] virt_st_data, virt_ld_data, phys_st_data, phys_ld_data;
    logic [28:0] phys_mem_addr;
    logic [7:0]  phys_we;
    logic [31:0] out_data;
    logic        out_req, out_busy;
    logic [7:0]  in_data;
    logic        in_valid, in_ready, io_stall;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] out_exp_q[$];
    logic [31:0] out_got_q[$];
    logic [63:0] ld_exp_q[$];
    logic [7:0]  in_exp_q[$];

    always #5 clk = ~clk;

    mmio_io_bridge #(
        .LOAD_LATENCY (LAT),
        .IO_BASE      (32'hfffff000),
        .OUT_DEPTH    (16),
        .IN_DEPTH     (16),
        .OUT_W        (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .virt_we       (virt_we),
        .virt_req      (virt_req),
        .virt_mem_addr (virt_mem_addr),
        .virt_mem_bmd  (virt_mem_bmd),
        .virt_st_data  (virt_st_data),
        .virt_ld_data  (virt_ld_data),
        .phys_mem_addr (phys_mem_addr),
        .phys_we       (phys_we),
        .phys_st_data  (phys_st_data),
        .phys_ld_data  (phys_ld_data),
        .out_data      (out_data),
        .out_req       (out_req),
        .out_busy      (out_busy),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .io_stall      (io_stall)
    );

    // Record every OUT transfer the sink would accept
    always @(posedge clk) begin
        if (rstn && out_req && !out_busy) out_got_q.push_back(out_data);
    end

    task automatic do_store(input logic [31:0] a, input logic [1:0] b, input logic [63:0] d,
                            output logic [7:0] we, output logic [63:0] sd,
                            output logic [28:0] pa, output logic stall);
        @(negedge clk);
        virt_req = 1'b1; virt_we = 1'b1; virt_mem_addr = a; virt_mem_bmd = b; virt_st_data = d;
        #1;
        we = phys_we; sd = phys_st_data; pa = phys_mem_addr; stall = io_stall;
        @(posedge clk); #1;
        virt_req = 1'b0; virt_we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] b, input logic [63:0] ram,
                           output logic [63:0] res);
        @(negedge clk);
        virt_req = 1'b1; virt_we = 1'b0; virt_mem_addr = a; virt_mem_bmd = b;
        @(negedge clk);
        virt_req = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        phys_ld_data = ram;
        #1;
        res = virt_ld_data;
    endtask

    task automatic send_in(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; out_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req: got %b want 0", out_req); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (io_stall !== 1'b0) begin n_fail++; $display("FAIL reset_io_stall: got %b want 0", io_stall); end
        n_tests++; if (phys_we !== 8'h00) begin n_fail++; $display("FAIL reset_phys_we: got %h want 00", phys_we); end
        n_tests++; if (virt_ld_data !== 64'd0) begin n_fail++; $display("FAIL reset_ld_data: got %h want 0", virt_ld_data); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_ram;
        logic [7:0]  we;
        logic [63:0] sd, r, e;
        logic [28:0] pa;
        logic        st;
        do_store(32'h0000_1005, 2'd0, 64'h0000_0000_0000_00AB, we, sd, pa, st);
        n_tests++; if (pa !== 29'h200) begin n_fail++; $display("FAIL byte_st_addr: got %h want 200", pa); end
        n_tests++; if (we !== 8'h04) begin n_fail++; $display("FAIL byte_st_we: got %h want 04", we); end
        n_tests++; if (sd[23:16] !== 8'hAB) begin n_fail++; $display("FAIL byte_st_data: got %h want ab", sd[23:16]); end
        do_store(32'h0000_1006, 2'd2, 64'h0000_0000_1122_3344, we, sd, pa, st);
        n_tests++; if (we !== 8'h0F) begin n_fail++; $display("FAIL word_st_we: got %h want 0f", we); end
        n_tests++; if (sd[31:0] !== 32'h1122_3344) begin n_fail++; $display("FAIL word_st_data: got %h want 11223344", sd[31:0]); end
        do_store(32'h0000_1003, 2'd3, 64'h0102_0304_0506_0708, we, sd, pa, st);
        n_tests++; if (we !== 8'hFF) begin n_fail++; $display("FAIL quad_st_we: got %h want ff", we); end
        n_tests++; if (sd !== 64'h0102_0304_0506_0708) begin n_fail++; $display("FAIL quad_st_data: got %h want 0102030405060708", sd); end
        do_store(IO_ST, 2'd2, 64'h0000_0000_DEAD_BEEF, we, sd, pa, st);
        n_tests++; if (we !== 8'h00) begin n_fail++; $display("FAIL io_st_no_ram: got %h want 00", we); end
        ld_exp_q.push_back(64'h6677);
        ld_exp_q.push_back(64'h11);
        ld_exp_q.push_back(64'h4455_6677);
        ld_exp_q.push_back(RAMW);
        do_load(32'h0000_1006, 2'd1, RAMW, r); e = ld_exp_q.pop_front();
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL half_ld: got %h want %h", r, e); end
        do_load(32'h0000_1001, 2'd0, RAMW, r); e = ld_exp_q.pop_front();
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL byte_ld: got %h want %h", r, e); end
        do_load(32'h0000_1005, 2'd2, RAMW, r); e = ld_exp_q.pop_front();
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL word_ld_align: got %h want %h", r, e); end
        do_load(32'h0000_1007, 2'd3, RAMW, r); e = ld_exp_q.pop_front();
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL quad_ld: got %h want %h", r, e); end
        @(negedge clk);
        phys_ld_data = 64'd0;
        @(negedge clk); #1;
        n_tests++; if (virt_ld_data !== RAMW) begin n_fail++; $display("FAIL ld_hold: got %h want %h", virt_ld_data, RAMW); end
    endtask

    task automatic test_out_fifo;
        logic [7:0]  we;
        logic [63:0] sd, r;
        logic [28:0] pa;
        logic        st;
        int          cyc;
        logic [31:0] e;
        @(negedge clk);
        out_busy = 1'b1;
        out_got_q.delete();
        for (int i = 0; i < 16; i++) begin
            do_store(IO_OUT, 2'd2, {32'd0, 32'hA000_0000 + i}, we, sd, pa, st);
            out_exp_q.push_back(32'hA000_0000 + i);
            n_tests++; if (st !== 1'b0) begin n_fail++; $display("FAIL out_push_stall %0d: got %b want 0", i, st); end
        end
        n_tests++; if (we !== 8'h00) begin n_fail++; $display("FAIL out_push_no_ram: got %h want 00", we); end
        do_load(IO_ST, 2'd2, RAMW, r);
        n_tests++; if (r !== 64'h1003) begin n_fail++; $display("FAIL out_full_status: got %h want 1003", r); end
        @(negedge clk);
        virt_req = 1'b1; virt_we = 1'b1; virt_mem_addr = IO_OUT; virt_mem_bmd = 2'd2;
        virt_st_data = 64'h0000_0000_A000_0010;
        #1;
        n_tests++; if (io_stall !== 1'b1) begin n_fail++; $display("FAIL out_stall_17: got %b want 1", io_stall); end
        @(negedge clk);
        out_busy = 1'b0;
        #1;
        n_tests++; if (io_stall !== 1'b1) begin n_fail++; $display("FAIL out_stall_hold: got %b want 1", io_stall); end
        @(posedge clk); #1;
        n_tests++; if (io_stall !== 1'b0) begin n_fail++; $display("FAIL out_stall_drop: got %b want 0", io_stall); end
        @(posedge clk); #1;
        out_exp_q.push_back(32'hA000_0010);
        virt_req = 1'b0; virt_we = 1'b0;
        cyc = 0;
        while (out_req && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL out_drain_timeout: got %b want 0", out_req); end
        n_tests++; if (out_got_q.size() != out_exp_q.size()) begin n_fail++; $display("FAIL out_count: got %0d want %0d", out_got_q.size(), out_exp_q.size()); end
        while (out_exp_q.size() > 0 && out_got_q.size() > 0) begin
            e = out_exp_q.pop_front();
            n_tests++; if (out_got_q[0] !== e) begin n_fail++; $display("FAIL out_order: got %h want %h", out_got_q[0], e); end
            void'(out_got_q.pop_front());
        end
        out_exp_q.delete();
    endtask

    task automatic test_in_read;
        logic [63:0] r;
        logic [7:0]  e;
        send_in(8'h41); in_exp_q.push_back(8'h41);
        send_in(8'h42); in_exp_q.push_back(8'h42);
        for (int i = 0; i < 2; i++) begin
            do_load(IO_IN, 2'd0, RAMW, r); e = in_exp_q.pop_front();
            n_tests++; if (r !== {56'd0, e}) begin n_fail++; $display("FAIL in_read %0d: got %h want %h", i, r, e); end
        end
        do_load(IO_IN, 2'd0, RAMW, r);
        n_tests++; if (r !== 64'd0) begin n_fail++; $display("FAIL in_read_empty: got %h want 0", r); end
        do_load(IO_ST, 2'd2, RAMW, r);
        n_tests++; if (r !== 64'h2) begin n_fail++; $display("FAIL in_empty_status: got %h want 2", r); end
    endtask

    task automatic test_in_full;
        logic [63:0] r;
        logic [7:0]  e;
        for (int i = 0; i < 16; i++) begin
            send_in(8'h60 + 8'(i));
            in_exp_q.push_back(8'h60 + 8'(i));
        end
        @(negedge clk); #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL in_full_ready: got %b want 0", in_ready); end
        do_load(IO_ST, 2'd2, RAMW, r);
        n_tests++; if (r !== 64'h0010_0000) begin n_fail++; $display("FAIL in_full_status: got %h want 100000", r); end
        in_valid = 1'b1; in_data = 8'h70;
        do_load(IO_IN, 2'd0, RAMW, r); e = in_exp_q.pop_front();
        n_tests++; if (r !== {56'd0, e}) begin n_fail++; $display("FAIL in_pop_full: got %h want %h", r, e); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_after_pop: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_exp_q.push_back(8'h70);
        do_load(IO_ST, 2'd2, RAMW, r);
        n_tests++; if (r !== 64'h0010_0000) begin n_fail++; $display("FAIL in_count_kept: got %h want 100000", r); end
        while (in_exp_q.size() > 0) begin
            do_load(IO_IN, 2'd0, RAMW, r); e = in_exp_q.pop_front();
            n_tests++; if (r !== {56'd0, e}) begin n_fail++; $display("FAIL in_order: got %h want %h", r, e); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0]  we;
        logic [63:0] sd, r;
        logic [28:0] pa;
        logic        st;
        @(negedge clk);
        out_busy = 1'b1;
        out_got_q.delete();
        for (int i = 0; i < 5; i++) begin
            do_store(IO_OUT, 2'd2, {32'd0, 32'hB000_0000 + i}, we, sd, pa, st);
        end
        @(negedge clk); #1;
        n_tests++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b want 1", out_req); end
        rstn = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_req: got %b want 0", out_req); end
        @(negedge clk);
        rstn = 1'b1; out_busy = 1'b0;
        do_load(IO_ST, 2'd2, RAMW, r);
        n_tests++; if (r !== 64'h2) begin n_fail++; $display("FAIL mid_reset_status: got %h want 2", r); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (out_got_q.size() != 0) begin n_fail++; $display("FAIL mid_reset_dropped: got %0d want 0", out_got_q.size()); end
    endtask

    initial begin
        rstn = 1'b0; virt_we = 1'b0; virt_req = 1'b0; virt_mem_addr = 32'd0;
        virt_mem_bmd = 2'd0; virt_st_data = 64'd0; phys_ld_data = 64'd0;
        out_busy = 1'b0; in_data = 8'd0; in_valid = 1'b0;
        test_reset();
        test_ram();
        test_out_fifo();
        test_in_read();
        test_in_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
